// File: rtl/md_bus_master_arb.sv
// md_bus_master_arb: arbitrates N internal bus masters onto the 68000 BR/BG/BGACK handshake.
module md_bus_master_arb #(
    parameter int N_REQ   = 4,
    parameter int RR_MODE = 0,
    parameter int TEN_W   = 8
) (
    input  logic             MCLK,
    input  logic             SRES,
    input  logic [N_REQ-1:0] REQ,
    input  logic [TEN_W-1:0] TENURE,
    input  logic             BG,
    input  logic             AS_i,
    input  logic             BGACK_i,
    output logic             BR_pull,
    output logic             BGACK_pull,
    output logic [N_REQ-1:0] GNT,
    output logic [2:0]       OWNER,
    output logic             TMO
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OWN, S_REL} state_t;

    state_t           state, state_n;
    logic [1:0]       bg_q, as_q, bgack_q;
    logic             bg_s, as_s, bgack_s;
    logic [2:0]       owner, last, win;
    logic [TEN_W-1:0] ten_cnt;
    logic [N_REQ-1:0] own_mask;
    logic             own_req, expire;

    function automatic logic [2:0] pick(input logic [N_REQ-1:0] r, input logic [2:0] l);
        logic [2:0]       w;
        logic [N_REQ-1:0] sh;
        int               k;
        w = '0;
        // scan from the far end so the nearest candidate is written last and wins
        for (int i = N_REQ; i >= 1; i--) begin
            k = (RR_MODE != 0) ? int'(l) + i : i - 1;
            if (k >= N_REQ) k = k - N_REQ;
            sh = r >> k;
            if (sh[0]) w = 3'(k);
        end
        return w;
    endfunction

    assign bg_s     = bg_q[1];
    assign as_s     = as_q[1];
    assign bgack_s  = bgack_q[1];
    assign win      = pick(REQ, last);
    assign own_mask = N_REQ'(1) << owner;
    assign own_req  = |(REQ & own_mask);
    assign expire   = (state == S_OWN) && (TENURE != '0) && (ten_cnt == TENURE - TEN_W'(1));
    assign OWNER    = owner;

    always_comb begin
        state_n    = state;
        BR_pull    = (state == S_REQ) || (state == S_WAIT);
        BGACK_pull = (state == S_OWN) || (state == S_REL);
        GNT        = (state == S_OWN) ? own_mask : '0;
        TMO        = expire;
        case (state)
            S_IDLE:  state_n = (|REQ) ? S_REQ : S_IDLE;
            S_REQ:   state_n = !own_req ? S_IDLE : !bg_s ? S_WAIT : S_REQ;
            S_WAIT:  state_n = !own_req ? S_IDLE : (as_s && bgack_s) ? S_OWN : S_WAIT;
            S_OWN:   state_n = (!own_req || expire) ? S_REL : S_OWN;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            bg_q    <= 2'b11;
            as_q    <= 2'b11;
            bgack_q <= 2'b11;
            state   <= S_IDLE;
            owner   <= '0;
            last    <= 3'(N_REQ - 1);
            ten_cnt <= '0;
        end else begin
            bg_q    <= {bg_q[0], BG};
            as_q    <= {as_q[0], AS_i};
            bgack_q <= {bgack_q[0], BGACK_i};
            state   <= state_n;
            if (state == S_IDLE && (|REQ)) owner <= win;
            if (state == S_REL) last <= owner;
            if (state_n == S_OWN && state != S_OWN) ten_cnt <= '0;
            else if (state == S_OWN && !(&ten_cnt)) ten_cnt <= ten_cnt + TEN_W'(1);
        end
    end
endmodule
